// File: rtl/aes_pkg.sv
// Shared constants, types and GF(2^8) helpers for the AES-128 key schedule.
// Contents:
//   KEY_W, NUM_ROUNDS, IDX_W : widths and round count
//   round_key_t              : one 128-bit round key
//   ks_state_t               : key-schedule controller states
//   gf_mul / sbox / rcon     : byte-level helpers used by roundKey
package aes_pkg;

  localparam int KEY_W      = 128;
  localparam int NUM_ROUNDS = 10;
  localparam int IDX_W      = 4;

  typedef logic [KEY_W-1:0] round_key_t;

  typedef enum logic {
    KS_IDLE,
    KS_EXPAND
  } ks_state_t;

  // Multiplication in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box computed rather than tabulated: multiplicative inverse as x^254
  // (which maps 0 to 0), followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] e;
    e   = 8'hfe;
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gf_mul(inv, inv);
      if (e[i]) inv = gf_mul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [IDX_W-1:0] round);
    logic [7:0] r;
    case (round)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_key_schedule_ctrl_round_key.sv
// roundKey: one combinational AES-128 key-expansion step.
// Ports:
//   key_in  : previous round key (byte 0 in [127:120], column-major)
//   round   : step index 0..9, selects Rcon
//   key_out : next round key
module roundKey
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] key_in,
  input  logic [IDX_W-1:0] round,
  output logic [KEY_W-1:0] key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w3;
  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key_in[127:96];
  assign w1 = key_in[95:64];
  assign w2 = key_in[63:32];
  assign w3 = key_in[31:0];

  assign rot_w3 = {w3[23:0], w3[31:24]};

  assign temp = {sbox(rot_w3[31:24]) ^ rcon(round),
                 sbox(rot_w3[23:16]),
                 sbox(rot_w3[15:8]),
                 sbox(rot_w3[7:0])};

  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key-schedule controller. Captures a cipher key on start, runs
// roundKey once per clock for rounds 0..9 and stores all 11 round keys in a
// flop buffer that the round datapath reads through a registered port.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start, key_in      : expansion request and cipher key (taken when ready)
//   ready, busy        : idle / expanding status
//   done               : one-cycle pulse after the last key is written
//   keys_valid         : level, all round keys present
//   rd_idx             : round-key index to read (0 = cipher key)
//   rd_key, rd_ok      : registered read data and its validity
//
// state     | meaning
// KS_IDLE   | waiting for start; buffer readable up to gen_cnt
// KS_EXPAND | writing one round key per cycle, round_cnt = 0..9
module aes_key_schedule_ctrl
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [KEY_W-1:0] rd_key,
  output logic             rd_ok
);

  ks_state_t        state_q, state_d;
  logic [IDX_W-1:0] round_cnt_q;
  logic [IDX_W-1:0] gen_cnt_q;
  round_key_t       cur_key_q;
  round_key_t       key_buf [0:NUM_ROUNDS];
  round_key_t       nxt_key;
  logic [IDX_W-1:0] wr_idx;
  logic             load, step, last;
  logic             done_q, keys_valid_q;
  logic             rd_hit;

  roundKey u_round_key (
    .key_in  (cur_key_q),
    .round   (round_cnt_q),
    .key_out (nxt_key)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      KS_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = KS_EXPAND;
        end
      end
      KS_EXPAND: begin
        step = 1'b1;
        if (round_cnt_q == IDX_W'(NUM_ROUNDS - 1)) begin
          last    = 1'b1;
          state_d = KS_IDLE;
        end
      end
      default: state_d = KS_IDLE;
    endcase
  end

  assign wr_idx = round_cnt_q + 1'b1;
  // gen_cnt counts keys written for the current load, so stale entries from
  // an earlier key or an aborted expansion are never readable.
  assign rd_hit = (rd_idx < gen_cnt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= KS_IDLE;
      round_cnt_q  <= '0;
      gen_cnt_q    <= '0;
      cur_key_q    <= '0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      rd_key       <= '0;
      rd_ok        <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last;
      if (load) begin
        cur_key_q    <= key_in;
        round_cnt_q  <= '0;
        gen_cnt_q    <= IDX_W'(1);
        keys_valid_q <= 1'b0;
      end else if (step) begin
        cur_key_q   <= nxt_key;
        round_cnt_q <= round_cnt_q + 1'b1;
        gen_cnt_q   <= gen_cnt_q + 1'b1;
        if (last) keys_valid_q <= 1'b1;
      end
      rd_ok  <= rd_hit;
      rd_key <= rd_hit ? key_buf[rd_idx] : '0;
    end
  end

  // Buffer has no reset; its contents are hidden until gen_cnt covers them.
  always_ff @(posedge clk) begin
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (!rst) begin
        if (load && i == 0) begin
          key_buf[i] <= key_in;
        end else if (step && wr_idx == IDX_W'(i)) begin
          key_buf[i] <= nxt_key;
        end
      end
    end
  end

  assign ready      = (state_q == KS_IDLE);
  assign busy       = (state_q == KS_EXPAND);
  assign done       = done_q;
  assign keys_valid = keys_valid_q;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
module tb_aes_key_schedule_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         ready, busy, done, keys_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         rd_ok;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K0     = 128'h0;
  localparam logic [127:0] K0_1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] K0_10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] KOTHER = 128'hdeadbeef0123456789abcdeffedcba98;

  aes_key_schedule_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_in     (key_in),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key),
    .rd_ok      (rd_ok)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_read(input string tag, input int idx, input logic exp_ok,
                            input logic [127:0] exp_key);
    @(negedge clk);
    rd_idx = idx[3:0];
    @(posedge clk);
    #1;
    check_val({tag, " rd_ok"}, rd_ok, exp_ok);
    check_val({tag, " rd_key"}, rd_key, exp_key);
  endtask

  // poll: 0 none, 1 read idx c at cycle c (must not yet be valid),
  //       2 hold idx 10 and record the cycle rd_ok first rises.
  task automatic run_expand(input logic [127:0] k, input bit glitch, input int rst_at,
                            input int poll, output int done_at, output int done_n,
                            output int ok_rise);
    done_at = 0;
    done_n  = 0;
    ok_rise = 0;
    @(negedge clk);
    start  = 1'b1;
    key_in = k;
    if (poll == 2) rd_idx = 4'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_val("accept ready", ready, 1'b0);
    check_val("accept busy", busy, 1'b1);
    check_val("accept keys_valid", keys_valid, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start  = glitch && (c == 3 || c == 7);
      key_in = start ? KOTHER : k;
      rst    = (c == rst_at);
      if (poll == 1) rd_idx = c[3:0];
      @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      check_val($sformatf("ready&busy c%0d", c), ready & busy, 1'b0);
      if (done) begin
        done_n++;
        if (done_at == 0) done_at = c;
      end
      if (poll == 1) check_val($sformatf("early rd_ok idx%0d", c), rd_ok, 1'b0);
      if (poll == 2 && rd_ok && ok_rise == 0) ok_rise = c;
      if (rst_at == 0 && poll != 2 && done_n > 0) break;
      if (poll == 2 && c == 12) break;
    end
  endtask

  int d_at, d_n, ok_r;

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    key_in = '0;
    rd_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset ready", ready, 1'b1);
    check_val("reset busy", busy, 1'b0);
    check_val("reset done", done, 1'b0);
    check_val("reset keys_valid", keys_valid, 1'b0);
    check_val("reset rd_ok", rd_ok, 1'b0);
    check_val("reset rd_key", rd_key, '0);
    @(negedge clk);
    rst = 1'b0;
    check_read("post-reset idx0", 0, 1'b0, '0);

    // FIPS-197 vector
    run_expand(K1, 1'b0, 0, 0, d_at, d_n, ok_r);
    check_val("t1 done latency", d_at, 10);
    check_val("t1 keys_valid", keys_valid, 1'b1);
    check_val("t1 ready", ready, 1'b1);
    check_read("t1 idx1", 1, 1'b1, K1_1);
    check_val("t1 done cleared", done, 1'b0);
    check_read("t1 idx10", 10, 1'b1, K1_10);
    check_read("t1 idx0", 0, 1'b1, K1);

    // all-zero key
    run_expand(K0, 1'b0, 0, 0, d_at, d_n, ok_r);
    check_val("t2 done latency", d_at, 10);
    check_read("t2 idx1", 1, 1'b1, K0_1);
    check_read("t2 idx10", 10, 1'b1, K0_10);

    // start pulses during expansion are ignored
    run_expand(K1, 1'b1, 0, 0, d_at, d_n, ok_r);
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) d_n++;
    end
    check_val("t3 done latency", d_at, 10);
    check_val("t3 done pulses", d_n, 1);
    check_read("t3 idx0", 0, 1'b1, K1);
    check_read("t3 idx1", 1, 1'b1, K1_1);
    check_read("t3 idx10", 10, 1'b1, K1_10);

    // keys not readable before their write edge
    run_expand(K0, 1'b0, 0, 1, d_at, d_n, ok_r);
    check_val("t5 done latency", d_at, 10);
    for (int i = 11; i <= 15; i++)
      check_read($sformatf("t5 idx%0d", i), i, 1'b0, '0);

    // reset mid-expansion
    run_expand(K1, 1'b0, 5, 0, d_at, d_n, ok_r);
    check_val("t4 done pulses", d_n, 0);
    check_val("t4 ready", ready, 1'b1);
    check_val("t4 keys_valid", keys_valid, 1'b0);
    for (int i = 0; i <= 10; i++)
      check_read($sformatf("t4 idx%0d", i), i, 1'b0, '0);
    run_expand(K0, 1'b0, 0, 2, d_at, d_n, ok_r);
    check_val("t4 re-expand latency", d_at, 10);
    check_val("t5 idx10 rd_ok rise cycle", ok_r, 11);
    check_read("t4 idx10", 10, 1'b1, K0_10);

    // back-to-back restart right after done
    run_expand(K1, 1'b0, 0, 0, d_at, d_n, ok_r);
    check_val("t6 first latency", d_at, 10);
    check_val("t6 keys_valid before restart", keys_valid, 1'b1);
    run_expand(K0, 1'b0, 0, 0, d_at, d_n, ok_r);
    check_val("t6 second latency", d_at, 10);
    check_read("t6 idx1", 1, 1'b1, K0_1);
    check_read("t6 idx10", 10, 1'b1, K0_10);
    check_read("t6 idx0", 0, 1'b1, K0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule_ctrl.md
Name: aes_key_schedule_ctrl

Overview:
Sequences the combinational roundKey stage through all AES-128 rounds. It captures a cipher key on a start handshake and iterates roundKey once per clock with round index 0..9. The resulting 11 round keys are stored in an internal key buffer. The cipher round datapath reads that buffer through a registered, indexed read port, so key expansion happens once per key load.

Parameters:
KEY_W, 128, round-key width in bits (packed column-major, byte 0 in bits [127:120]).
NUM_ROUNDS, 10, number of expansion steps; buffer holds NUM_ROUNDS+1 keys.
IDX_W, 4, width of round/read index.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  reset, synchronous, active-high.
start  in  1  request expansion of key_in; accepted only when ready=1.
key_in  in  KEY_W  cipher key, sampled on accepted start.
ready  out  1  controller idle; start will be accepted.
busy  out  1  expansion in progress.
done  out  1  one-cycle pulse after the last round key is written.
keys_valid  out  1  all NUM_ROUNDS+1 keys present; level signal.
rd_idx  in  IDX_W  round-key index to read (0 = cipher key).
rd_key  out  KEY_W  registered read data.
rd_ok  out  1  registered: rd_key holds a generated key.

Behaviour:
- Reset, synchronous with rst=1 at a clk edge:
  - state=IDLE, gen_cnt=0, round_cnt=0.
  - ready=1, busy=0, done=0, keys_valid=0, rd_key=0, rd_ok=0.
  - Buffer contents are don't-care; they are invisible because gen_cnt=0.
- FSM states: IDLE, EXPAND.
- IDLE, start=1:
  - buf[0]<=key_in; cur_key<=key_in; round_cnt<=0; gen_cnt<=1.
  - keys_valid<=0; go to EXPAND.
- EXPAND, each cycle:
  - nxt=roundKey(cur_key, round_cnt).
  - buf[round_cnt+1]<=nxt; cur_key<=nxt; gen_cnt<=gen_cnt+1; round_cnt<=round_cnt+1.
  - When round_cnt==NUM_ROUNDS-1, the same edge also sets done<=1 and keys_valid<=1 and returns to IDLE.
- Latency: start accepted at edge E0. Keys 1..10 are written at edges E1..E10. done=1 and keys_valid=1 after E10. Total is 10 cycles from accept to done.
- done is high for exactly one cycle and is cleared the cycle after it is set.
- ready=(state==IDLE); busy=(state==EXPAND); they are never both 1.
- start is ignored while busy, with no effect on state, counters or key.
- A start while keys_valid=1 (restart) is accepted:
  - keys_valid drops on the accept edge.
  - The old buffer entries become invisible through gen_cnt.
- Read port:
  - At every edge: rd_ok<=(rd_idx<gen_cnt) and rd_key<=rd_ok_cond ? buf[rd_idx] : 0.
  - One-cycle latency; reads are legal in any state.
  - A key is readable the cycle after its write edge. Read-during-write of the same index returns the old (pre-write) data.
  - rd_idx>NUM_ROUNDS gives rd_ok=0 and rd_key=0 (no wrap-around).
- round input to roundKey is round_cnt (0..9). round_cnt never reaches NUM_ROUNDS while in EXPAND.
- Reset mid-expansion: returns to the full reset state at that edge. Any partial keys are invisible and no done pulse is produced.
- rst has priority over start.

Decomposition:
- Package aes_pkg holds:
  - KEY_W, NUM_ROUNDS, IDX_W constants;
  - typedef round_key_t (logic [KEY_W-1:0]);
  - enum ks_state_t {KS_IDLE, KS_EXPAND}.
- Sub-module: the existing roundKey is instantiated once, combinationally, with key_in=cur_key, round=round_cnt and key_out=nxt. No other sub-modules.
- The buffer is an array of NUM_ROUNDS+1 round_key_t registers, synthesised as flops.

Test Plan:
1. FIPS-197 key vector.
   - Stimulus: start with key_in=2b7e151628aed2a6abf7158809cf4f3c.
   - Response: done exactly 10 cycles after accept.
   - Read idx1 = a0fafe1788542cb123a339392a6c7605.
   - Read idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
   - Read idx0 = the input key; rd_ok=1 for each read.
2. All-zero key.
   - Response: idx1 = 62636363626363636263636362636363.
   - Response: idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
3. Start during expansion.
   - Stimulus: start pulses with a different key at cycles 3 and 7 after accept.
   - Response: ignored; results identical to test 1; a single done pulse.
4. Reset mid-expansion.
   - Stimulus: rst at cycle 5.
   - Response: ready=1, keys_valid=0, no done pulse, reads of idx0..10 return rd_ok=0 and rd_key=0.
   - Then a new start expands correctly.
5. Read boundaries.
   - idx 11..15 → rd_ok=0, rd_key=0.
   - During expansion, idx k returns rd_ok=1 only after edge Ek.
   - Polling idx10 shows rd_ok rise the cycle after done.
6. Back-to-back restart.
   - Stimulus: start in the cycle after done with the zero key.
   - Response: keys_valid falls on the accept edge, done follows 10 cycles later, and the buffer holds the test 2 values.
